// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma datapath: alphabet size, rotor select
// encodings, sequencer states and the mod-26 helpers used by every stage.
package enigma_pkg;

  localparam int ALPHA  = 26;
  localparam int CHAR_W = 6;

  localparam logic [CHAR_W-1:0] ALPHA_C     = 6'd26;
  localparam logic [CHAR_W-1:0] LAST_LETTER = 6'd25;

  localparam logic [1:0] ROT_R = 2'd0;
  localparam logic [1:0] ROT_M = 2'd1;
  localparam logic [1:0] ROT_L = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_PASS_R,
    ST_PASS_M,
    ST_PASS_L,
    ST_DONE
  } seq_state_e;

  // (a + b) mod 26 for operands already in 0..25; the 6-bit sum tops out at 50.
  function automatic logic [CHAR_W-1:0] add_mod26(input logic [CHAR_W-1:0] a,
                                                  input logic [CHAR_W-1:0] b);
    logic [CHAR_W-1:0] sum;
    sum = a + b;
    return (sum >= ALPHA_C) ? sum - ALPHA_C : sum;
  endfunction

  // (a - b) mod 26 for operands already in 0..25.
  function automatic logic [CHAR_W-1:0] sub_mod26(input logic [CHAR_W-1:0] a,
                                                  input logic [CHAR_W-1:0] b);
    return (a < b) ? a + ALPHA_C - b : a - b;
  endfunction

  // Pull an out-of-range 6-bit value back into 0..25: one subtraction of 26,
  // then clamp whatever is still too large to Z.
  function automatic logic [CHAR_W-1:0] fold26(input logic [CHAR_W-1:0] x);
    logic [CHAR_W-1:0] y;
    y = (x >= ALPHA_C) ? x - ALPHA_C : x;
    return (y > LAST_LETTER) ? LAST_LETTER : y;
  endfunction

  // Advance one rotor position with wrap 25 -> 0.
  function automatic logic [CHAR_W-1:0] wrap_inc(input logic [CHAR_W-1:0] p);
    return (p >= LAST_LETTER) ? '0 : p + 6'd1;
  endfunction

endpackage

// File: rtl/enigma_stepper.sv
// Combinational rotor odometer. Works from pre-step positions, so a middle
// rotor sitting on its notch carries the left rotor and steps itself
// (the double step) in the same move.
module enigma_stepper
  import enigma_pkg::*;
(
  input  logic [CHAR_W-1:0] pos_l,
  input  logic [CHAR_W-1:0] pos_m,
  input  logic [CHAR_W-1:0] pos_r,
  input  logic [CHAR_W-1:0] notch_r,
  input  logic [CHAR_W-1:0] notch_m,
  output logic [CHAR_W-1:0] next_l,
  output logic [CHAR_W-1:0] next_m,
  output logic [CHAR_W-1:0] next_r
);

  logic carry_m;
  logic carry_l;

  // Right always steps; middle on right notch or its own notch; left on middle notch.
  always_comb begin
    carry_l = (pos_m == notch_m);
    carry_m = (pos_r == notch_r) || carry_l;
    next_r  = wrap_inc(pos_r);
    next_m  = carry_m ? wrap_inc(pos_m) : pos_m;
    next_l  = carry_l ? wrap_inc(pos_l) : pos_l;
  end

endmodule

// File: rtl/enigma_rotor_sequencer.sv
// Owns the three rotor positions and time-multiplexes one shared rotor
// lookup across the right, middle and left forward passes.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | in_ready high; loads honoured; accept next character
//  ST_STEP   | advance rotors, present right-pass lookup address
//  ST_PASS_R | right rotor lookup on the shared instance
//  ST_PASS_M | middle rotor lookup
//  ST_PASS_L | left rotor lookup, result captured into out_char
//  ST_DONE   | out_valid high until out_ready
//
// Non-letters (in_char >= 26) ride through the same states untouched with
// the lookup bus parked at 0, so latency is identical for every character.
module enigma_rotor_sequencer
  import enigma_pkg::*;
#(
  parameter logic [CHAR_W-1:0] NOTCH_R = 6'd16,
  parameter logic [CHAR_W-1:0] NOTCH_M = 6'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [CHAR_W-1:0] load_pos_l,
  input  logic [CHAR_W-1:0] load_pos_m,
  input  logic [CHAR_W-1:0] load_pos_r,
  input  logic [CHAR_W-1:0] in_char,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [1:0]        rot_sel,
  output logic [CHAR_W-1:0] rot_index,
  input  logic [CHAR_W-1:0] rot_result,
  output logic [CHAR_W-1:0] out_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] pos_l,
  output logic [CHAR_W-1:0] pos_m,
  output logic [CHAR_W-1:0] pos_r
);

  seq_state_e        state;
  logic [CHAR_W-1:0] data;
  logic              bypass;
  logic [CHAR_W-1:0] step_l, step_m, step_r;
  logic [CHAR_W-1:0] cur_pos;
  logic [CHAR_W-1:0] data_next;

  enigma_stepper u_stepper (
    .pos_l   (pos_l),
    .pos_m   (pos_m),
    .pos_r   (pos_r),
    .notch_r (NOTCH_R),
    .notch_m (NOTCH_M),
    .next_l  (step_l),
    .next_m  (step_m),
    .next_r  (step_r)
  );

  // Position of the rotor currently on the shared lookup, and the data after it.
  always_comb begin
    case (state)
      ST_PASS_R: cur_pos = pos_r;
      ST_PASS_M: cur_pos = pos_m;
      default:   cur_pos = pos_l;
    endcase
    data_next = sub_mod26(fold26(rot_result), cur_pos);
  end

  // Sequencer FSM; every output is registered so the lookup bus is steady per pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_char  <= '0;
      rot_sel   <= ROT_R;
      rot_index <= '0;
      data      <= '0;
      bypass    <= 1'b0;
      pos_l     <= '0;
      pos_m     <= '0;
      pos_r     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_en) begin
            pos_l <= fold26(load_pos_l);
            pos_m <= fold26(load_pos_m);
            pos_r <= fold26(load_pos_r);
          end
          if (in_valid) begin
            data     <= in_char;
            bypass   <= (in_char >= ALPHA_C);
            in_ready <= 1'b0;
            state    <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (!bypass) begin
            pos_l     <= step_l;
            pos_m     <= step_m;
            pos_r     <= step_r;
            rot_index <= add_mod26(data, step_r);
          end
          rot_sel <= ROT_R;
          state   <= ST_PASS_R;
        end
        ST_PASS_R: begin
          if (!bypass) begin
            data      <= data_next;
            rot_sel   <= ROT_M;
            rot_index <= add_mod26(data_next, pos_m);
          end
          state <= ST_PASS_M;
        end
        ST_PASS_M: begin
          if (!bypass) begin
            data      <= data_next;
            rot_sel   <= ROT_L;
            rot_index <= add_mod26(data_next, pos_l);
          end
          state <= ST_PASS_L;
        end
        ST_PASS_L: begin
          if (!bypass) data <= data_next;
          out_char  <= bypass ? data : data_next;
          out_valid <= 1'b1;
          rot_sel   <= ROT_R;
          rot_index <= '0;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_rotor_sequencer.sv
// Scoreboard bench: two sequencers (default notches and notches at 25/25)
// share stimulus; an arithmetic reference model predicts every character.
module tb_enigma_rotor_sequencer;

  logic       clk;
  logic       rst_n;
  logic       load_en;
  logic [5:0] load_pos_l, load_pos_m, load_pos_r;
  logic [5:0] in_char;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready_a  [2];
  logic       out_valid_a [2];
  logic [5:0] out_char_a  [2];
  logic [1:0] rot_sel_a   [2];
  logic [5:0] rot_index_a [2];
  logic [5:0] rot_result_a[2];
  logic [5:0] pos_l_a     [2];
  logic [5:0] pos_m_a     [2];
  logic [5:0] pos_r_a     [2];

  typedef struct {
    int out_v;
    int pl, pm, pr;
    int i0, i1, i2;
    bit byp;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int wiring[3][26];
  bit plus26;
  bit hold;
  int n_checks, n_pass;
  int cyc[2];
  int ridx[2][3];
  int rsel[2][3];
  int ml[2], mm[2], mr[2];
  int notch_r_m[2];
  int notch_m_m[2];

  enigma_rotor_sequencer #(.NOTCH_R(6'd16), .NOTCH_M(6'd4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load_en(load_en),
    .load_pos_l(load_pos_l), .load_pos_m(load_pos_m), .load_pos_r(load_pos_r),
    .in_char(in_char), .in_valid(in_valid), .in_ready(in_ready_a[0]),
    .rot_sel(rot_sel_a[0]), .rot_index(rot_index_a[0]), .rot_result(rot_result_a[0]),
    .out_char(out_char_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready),
    .pos_l(pos_l_a[0]), .pos_m(pos_m_a[0]), .pos_r(pos_r_a[0])
  );

  enigma_rotor_sequencer #(.NOTCH_R(6'd25), .NOTCH_M(6'd25)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_en(load_en),
    .load_pos_l(load_pos_l), .load_pos_m(load_pos_m), .load_pos_r(load_pos_r),
    .in_char(in_char), .in_valid(in_valid), .in_ready(in_ready_a[1]),
    .rot_sel(rot_sel_a[1]), .rot_index(rot_index_a[1]), .rot_result(rot_result_a[1]),
    .out_char(out_char_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready),
    .pos_l(pos_l_a[1]), .pos_m(pos_m_a[1]), .pos_r(pos_r_a[1])
  );

  function automatic logic [5:0] lookup(input logic [1:0] s, input logic [5:0] i);
    if (s > 2'd2 || i > 6'd25) return 6'd0;
    return 6'(wiring[s][i] + (plus26 ? 26 : 0));
  endfunction

  assign rot_result_a[0] = lookup(rot_sel_a[0], rot_index_a[0]);
  assign rot_result_a[1] = lookup(rot_sel_a[1], rot_index_a[1]);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int fold(input int v);
    int y;
    y = (v >= 26) ? v - 26 : v;
    return (y > 25) ? 25 : y;
  endfunction

  task automatic model_load(input int l, input int m, input int r);
    for (int k = 0; k < 2; k++) begin
      ml[k] = fold(l); mm[k] = fold(m); mr[k] = fold(r);
    end
  endtask

  task automatic model_char(input int c);
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      int d;
      bit cm, cl;
      e.byp = (c >= 26);
      e.i0 = 0; e.i1 = 0; e.i2 = 0;
      if (e.byp) begin
        e.out_v = c;
      end else begin
        cl = (mm[k] == notch_m_m[k]);
        cm = cl || (mr[k] == notch_r_m[k]);
        mr[k] = (mr[k] + 1) % 26;
        if (cm) mm[k] = (mm[k] + 1) % 26;
        if (cl) ml[k] = (ml[k] + 1) % 26;
        d = c;
        e.i0 = (d + mr[k]) % 26; d = (wiring[0][e.i0] - mr[k] + 26) % 26;
        e.i1 = (d + mm[k]) % 26; d = (wiring[1][e.i1] - mm[k] + 26) % 26;
        e.i2 = (d + ml[k]) % 26; d = (wiring[2][e.i2] - ml[k] + 26) % 26;
        e.out_v = d;
      end
      e.pl = ml[k]; e.pm = mm[k]; e.pr = mr[k];
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic set_identity();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 26; i++) wiring[s][i] = i;
  endtask

  task automatic set_random_wiring();
    int j, t;
    set_identity();
    for (int s = 0; s < 3; s++)
      for (int i = 25; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = wiring[s][i]; wiring[s][i] = wiring[s][j]; wiring[s][j] = t;
      end
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int k);
    exp_t e;
    int sz;
    if (!rst_n) begin cyc[k] = -1; return; end
    if (cyc[k] < 0) begin
      if (in_valid && in_ready_a[k]) cyc[k] = 0;
      return;
    end
    cyc[k]++;
    if (cyc[k] == 1) chk("busy_in_ready", k, in_ready_a[k], 0);
    if (cyc[k] >= 2 && cyc[k] <= 4) begin
      ridx[k][cyc[k]-2] = rot_index_a[k];
      rsel[k][cyc[k]-2] = rot_sel_a[k];
    end
    if (cyc[k] == 4) chk("early_valid", k, out_valid_a[k], 0);
    if (cyc[k] == 5) chk("latency_valid", k, out_valid_a[k], 1);
    if (cyc[k] >= 5 && out_valid_a[k]) begin
      sz = (k == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        chk("sb_nonempty", k, sz, 1);
        cyc[k] = -1;
      end else begin
        e = (k == 0) ? q0[0] : q1[0];
        chk("out_char", k, out_char_a[k], e.out_v);
        if (out_ready) begin
          chk("pos_l", k, pos_l_a[k], e.pl);
          chk("pos_m", k, pos_m_a[k], e.pm);
          chk("pos_r", k, pos_r_a[k], e.pr);
          chk("idx_r", k, ridx[k][0], e.i0);
          chk("idx_m", k, ridx[k][1], e.i1);
          chk("idx_l", k, ridx[k][2], e.i2);
          chk("sel_r", k, rsel[k][0], 0);
          chk("sel_m", k, rsel[k][1], e.byp ? 0 : 1);
          chk("sel_l", k, rsel[k][2], e.byp ? 0 : 2);
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          cyc[k] = -1;
        end
      end
    end
    if (cyc[k] > 60) begin
      chk("done_timeout", k, cyc[k], 60);
      cyc[k] = -1;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // ---------------- stimulus helpers ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready_a[0] && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("ready_timeout", 0, in_ready_a[0], 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || !in_ready_a[0]) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("idle_timeout", 0, q0.size() + q1.size(), 0);
  endtask

  task automatic do_load(input int l, input int m, input int r);
    wait_ready();
    load_en = 1'b1;
    load_pos_l = 6'(l); load_pos_m = 6'(m); load_pos_r = 6'(r);
    model_load(l, m, r);
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Issues one character (optionally with a same-cycle load); returns 1ns after the accept edge.
  task automatic send(input int c, input bit ld, input int l, input int m, input int r);
    wait_ready();
    if (ld) begin
      load_en = 1'b1;
      load_pos_l = 6'(l); load_pos_m = 6'(m); load_pos_r = 6'(r);
      model_load(l, m, r);
    end
    in_valid = 1'b1;
    in_char  = 6'(c);
    model_char(c);
    @(posedge clk); #1;
    in_valid = 1'b0;
    load_en  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_in_ready"}, k, in_ready_a[k], 1);
      chk({tag, "_out_valid"}, k, out_valid_a[k], 0);
      chk({tag, "_out_char"}, k, out_char_a[k], 0);
      chk({tag, "_rot_sel"}, k, rot_sel_a[k], 0);
      chk({tag, "_rot_index"}, k, rot_index_a[k], 0);
      chk({tag, "_pos"}, k, {pos_l_a[k], pos_m_a[k], pos_r_a[k]}, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c, n;
    n_checks = 0; n_pass = 0;
    cyc[0] = -1; cyc[1] = -1;
    notch_r_m[0] = 16; notch_m_m[0] = 4;
    notch_r_m[1] = 25; notch_m_m[1] = 25;
    for (int k = 0; k < 2; k++) begin ml[k] = 0; mm[k] = 0; mr[k] = 0; end
    plus26 = 1'b0; hold = 1'b0;
    rst_n = 1'b0; load_en = 1'b0; in_valid = 1'b0; in_char = '0;
    load_pos_l = '0; load_pos_m = '0; load_pos_r = '0;
    set_identity();
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;

    // identity wiring, origin
    do_load(0, 0, 0);
    send(0, 0, 0, 0, 0);
    wait_idle();
    chk("t1_pos_r", 0, pos_r_a[0], 1);
    chk("t1_out", 0, out_char_a[0], 0);

    // normal carry then no further middle step
    do_load(0, 0, 16);
    send(3, 0, 0, 0, 0);
    wait_idle();
    chk("carry_pos_m", 0, pos_m_a[0], 1);
    send(4, 0, 0, 0, 0);
    wait_idle();
    chk("carry2_pos", 0, {pos_l_a[0], pos_m_a[0], pos_r_a[0]}, {6'd0, 6'd1, 6'd18});

    // double step
    do_load(0, 3, 16);
    send(1, 0, 0, 0, 0);
    send(2, 0, 0, 0, 0);
    wait_idle();
    chk("dbl_pos", 0, {pos_l_a[0], pos_m_a[0], pos_r_a[0]}, {6'd1, 6'd5, 6'd18});

    // full wrap on the 25/25 instance
    do_load(25, 25, 25);
    send(7, 0, 0, 0, 0);
    wait_idle();
    chk("wrap_pos", 1, {pos_l_a[1], pos_m_a[1], pos_r_a[1]}, 0);

    // mod arithmetic: right at 25, data 24 -> index 23; wiring 23->2 -> data 3
    wiring[0][23] = 2; wiring[0][2] = 23;
    do_load(25, 25, 24);
    send(24, 0, 0, 0, 0);
    wait_idle();
    set_random_wiring();

    // backpressure for 10 cycles with in_valid ignored
    hold = 1'b1;
    send(5, 0, 0, 0, 0);
    n = 0;
    while (!out_valid_a[0] && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_char = 6'd9;
      @(posedge clk); #1;
      chk("hold_valid", 0, out_valid_a[0], 1);
      chk("hold_in_ready", 0, in_ready_a[0], 0);
    end
    in_valid = 1'b0;
    hold = 1'b0;
    wait_idle();

    // simultaneous load + character, out-of-range load values
    send(11, 1, 40, 63, 16);
    wait_idle();

    // load during PASS_M is ignored
    send(12, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    load_en = 1'b1; load_pos_l = 6'd9; load_pos_m = 6'd9; load_pos_r = 6'd9;
    @(posedge clk); #1;
    load_en = 1'b0;
    send(13, 0, 0, 0, 0);
    wait_idle();

    // non-letter passthrough
    send(40, 0, 0, 0, 0);
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      wait_ready();
      if ($urandom_range(0, 7) == 0) set_random_wiring();
      plus26 = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(26, 63)) : int'($urandom_range(0, 25));
      if ($urandom_range(0, 5) == 0)
        send(c, 1, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
      else
        send(c, 0, 0, 0, 0);
      wait_idle();
    end
    plus26 = 1'b0;

    // reset during PASS_M
    do_load(3, 4, 16);
    send(6, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    q0.delete(); q1.delete();
    model_load(0, 0, 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;

    // recovery after reset
    send(8, 0, 0, 0, 0);
    send(30, 0, 0, 0, 0);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/enigma_rotor_sequencer.md
# enigma_rotor_sequencer

Sequencer that owns the three rotor positions of the Enigma datapath and time-multiplexes one shared rotor lookup instance across the right, middle and left rotor passes. Per accepted character it steps the rotors (including the middle-rotor double step), then drives three lookup cycles with mod-26 position offsets applied. The result is presented on a valid/ready output toward the reflector stage. It sits between the keyboard/UART character source and the reflector/return path.

## Interface
- NOTCH_R, 16 (Q): right-rotor position at which the middle rotor is carried.
- NOTCH_M, 4 (E): middle-rotor position at which the left rotor is carried and the middle rotor double-steps.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load_en  in  1  load rotor start positions; honoured only in IDLE.
- load_pos_l / load_pos_m / load_pos_r  in  6 each  start positions, 0..25.
- in_char  in  6  plaintext character, 0..25 = A..Z.
- in_valid  in  1  in_char valid.
- in_ready  out  1  sequencer can accept a character.
- rot_sel  out  2  shared lookup wiring select: 0 = right, 1 = middle, 2 = left.
- rot_index  out  6  lookup address, always 0..25.
- rot_result  in  6  combinational lookup return, same cycle.
- out_char  out  6  forward-path result.
- out_valid  out  1  out_char valid.
- out_ready  in  1  downstream accepts out_char.
- pos_l / pos_m / pos_r  out  6 each  current rotor positions, for display.

## Operation
- States: IDLE, STEP, PASS_R, PASS_M, PASS_L, DONE.
- IDLE: in_ready = 1.
  - load_en with no handshake: pos_* take load_pos_* values modulo 26. Values 26..63 are reduced by subtracting 26 once, then clamped to 25.
  - If in_valid and load_en occur in the same cycle, the load applies first. The character then steps from the loaded positions.
  - On in_valid & in_ready: latch in_char into a data register, go to STEP.
- STEP: odometer using pre-step positions.
  - Right always advances.
  - Middle advances if pos_r == NOTCH_R or pos_m == NOTCH_M.
  - Left advances if pos_m == NOTCH_M.
  - All positions wrap 25 -> 0.
- PASS_R / PASS_M / PASS_L: with the selected rotor position p and data d:
  - rot_index = (d + p) mod 26, computed as a 6-bit sum; subtract 26 if the sum is >= 26.
  - Next d = (rot_result - p) mod 26; add 26 if rot_result < p.
  - rot_result values >= 26 are treated as rot_result - 26.
- DONE: out_valid = 1, out_char = d. Return to IDLE when out_ready is high.
- in_char >= 26 (non-letter): the character is accepted, but no step and no lookup are applied. It is passed unchanged to out_char with the same latency. rot_sel / rot_index are held at 0 during those cycles.
- load_en outside IDLE is ignored.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_char 0, pos_* 0, rot_sel 0, rot_index 0, data register 0.
- Cycle 0: handshake. Cycle 1: STEP, so new pos_* are visible at the cycle-2 edge. Cycles 2/3/4: PASS_R/M/L. Cycle 5: out_valid = 1.
  - Latency from accept to out_valid is 5 cycles.
  - Throughput is at most one character per 6 cycles.
- out_valid and out_char stay stable until out_ready. Backpressure holds DONE indefinitely.
- in_ready = 0 from the accept edge until the cycle after out_valid & out_ready. There is no overlap between characters.
- rot_sel / rot_index are registered-state driven and stable throughout each PASS cycle.
- Asynchronous reset mid-character: the character is abandoned, all outputs return to reset values immediately, and positions return to 0.

## Structure
- Shared package enigma_pkg contains:
  - ALPHA = 26
  - CHAR_W = 6
  - the rotor select encodings ROT_R/ROT_M/ROT_L
  - the sequencer state enum
  - functions add_mod26 / sub_mod26, reused by the reflector and return-path blocks
- One sub-module: enigma_stepper, the combinational odometer taking pos_* and NOTCH_* and returning next pos_*. It is instantiated once and is reusable for the stepping model in the bench.

## Test plan
- Reset, then positions loaded 0/0/0 with an identity-wiring lookup model; send in_char 0 → pos 0/0/1, out_char 0 at the 5th cycle after accept, and rot_index sequence 1,0,0.
- Normal carry: load 0/0/16; send one char → pos 0/1/17. Send another → pos 0/1/18, with no further middle step.
- Double step: load 0/3/16; char 1 → 0/4/17. Char 2 → 1/5/18, with middle and left advancing together.
- Wrap: load 25/25/25 with NOTCH_M = 25 and NOTCH_R = 25; send one char → 0/0/0. Mod arithmetic check: rot_index = (24 + 25) - 26 = 23, and rot_result 2 with p = 25 gives d = 3.
- Handshake: hold out_ready = 0 for 10 cycles → out_valid and out_char stable and in_valid ignored. Simultaneous load_en + in_valid in IDLE → stepping from the loaded positions. load_en during PASS_M → ignored.
- in_char = 40 → accepted, out_char = 40 after 5 cycles, pos_* unchanged. Assert rst_n low during PASS_M → outputs and positions at reset values that cycle, in_ready = 1.
